// File: rtl/seq_shift_add_multiplier_if.sv
// Handshake/data bundle between a controller FSM and the shift-add multiplier.
// Latency: none; plain wires grouping the request and result signals.
// Backpressure: none; the controller watches busy and only issues go while it is low.
//
// Signals: go/A/B (and tc when MULT_SIGNED_EN is defined) run controller -> multiplier;
//          busy/done/Result run multiplier -> controller.
// Modports: master = controller side, slave = multiplier side.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               go;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
`ifdef MULT_SIGNED_EN
  logic               tc;
`endif
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] Result;

`ifdef MULT_SIGNED_EN
  modport master (output go, A, B, tc, input busy, done, Result);
  modport slave  (input go, A, B, tc, output busy, done, Result);
`else
  modport master (output go, A, B, input busy, done, Result);
  modport slave  (input go, A, B, output busy, done, Result);
`endif
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Sequential radix-2 shift-add WIDTH x WIDTH multiplier with a held 2*WIDTH result.
// Latency: done pulses WIDTH+1 edges after go is presented (counting the accept edge), 1 edge for a zero operand.
// Backpressure: go is only sampled in IDLE; requests while busy are dropped, never queued.
//
// Ports: clk (rising edge), reset (async, active low),
//        bus (slave modport): go/A/B[/tc] in, busy/done/Result out.
// Optional feature macro: MULT_SIGNED_EN adds the tc input and two's-complement operation.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  seq_shift_add_multiplier_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [WIDTH-1:0]     acc_hi;
  // Low half of the accumulator without its bottom bit: that bit is shifted
  // out on the next iteration and never reaches the product, so it is not stored.
  logic [WIDTH-2:0]     acc_lo;
  logic [CNT_W-1:0]     cnt;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   result_r;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod_next;
  logic [2*WIDTH-1:0]   final_res;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 zero_op;

`ifdef MULT_SIGNED_EN
  logic                 neg_r;
  logic                 neg_in;
`endif

  // One iteration: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right (carry included).
  always_comb begin
    sum       = {1'b0, acc_hi} + (b_r[0] ? {1'b0, a_r} : '0);
    prod_next = {sum, acc_lo};
  end

`ifdef MULT_SIGNED_EN
  // Magnitudes fit WIDTH unsigned bits even for the most negative operand.
  always_comb begin
    a_mag     = (bus.tc && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag     = (bus.tc && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    neg_in    = bus.tc & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
    final_res = neg_r ? -prod_next : prod_next;
  end
`else
  always_comb begin
    a_mag     = bus.A;
    b_mag     = bus.B;
    final_res = prod_next;
  end
`endif

  assign zero_op = (bus.A == '0) || (bus.B == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
`ifdef MULT_SIGNED_EN
      neg_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.go) begin
            a_r    <= a_mag;
            b_r    <= b_mag;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
`ifdef MULT_SIGNED_EN
            neg_r  <= neg_in;
`endif
            if (zero_op) begin
              // Shortcut: product is known to be zero, skip the iterations.
              state    <= DONE;
              done_r   <= 1'b1;
              result_r <= '0;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          acc_hi <= prod_next[2*WIDTH-1:WIDTH];
          acc_lo <= prod_next[WIDTH-1:1];
          b_r    <= b_r >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // Last iteration: the shifted accumulator is the full product.
            state    <= DONE;
            done_r   <= 1'b1;
            result_r <= final_res;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.Result = result_r;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed and random checks of seq_shift_add_multiplier at WIDTH=8 and WIDTH=16.
// Expected products and latencies come from a reference model through a scoreboard queue.
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic tc_v;
  bit   sel;   // 0: 8-bit instance, 1: 16-bit instance

  seq_shift_add_multiplier_if #(.WIDTH(8))  m8 ();
  seq_shift_add_multiplier_if #(.WIDTH(16)) m16 ();

`ifdef MULT_SIGNED_EN
  assign m8.tc  = tc_v;
  assign m16.tc = tc_v;
`endif

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (m8.slave)
  );

  seq_shift_add_multiplier #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (m16.slave)
  );

  wire        cur_done = sel ? m16.done : m8.done;
  wire        cur_busy = sel ? m16.busy : m8.busy;
  wire [31:0] cur_res  = sel ? m16.Result : {16'b0, m8.Result};

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_res [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_prod(input bit s, input logic [15:0] a, input logic [15:0] b,
                                           input logic t);
    logic        [15:0] p8u;
    logic signed [15:0] p8s;
    logic        [31:0] p16u;
    logic signed [31:0] p16s;
    if (!s) begin
      p8u = 16'(a[7:0]) * 16'(b[7:0]);
      p8s = $signed(a[7:0]) * $signed(b[7:0]);
      return t ? {16'b0, p8s} : {16'b0, p8u};
    end
    p16u = 32'(a) * 32'(b);
    p16s = $signed(a) * $signed(b);
    return t ? p16s : p16u;
  endfunction

  task automatic drive(input logic g, input logic [15:0] a, input logic [15:0] b);
    if (sel) begin
      m16.go = g; m16.A = a;      m16.B = b;
    end else begin
      m8.go  = g; m8.A  = a[7:0]; m8.B  = b[7:0];
    end
  endtask

  // One operation: push the expectation, pulse go, wait for done, pop and compare.
  // poke >= 1 re-asserts go with other operands at that cycle of the calculation.
  task automatic run(input logic [15:0] a, input logic [15:0] b, input int poke);
    exp_t e;
    exp_t got;
    int   n;
    int   busy_n;
    bit   is_zero;
    is_zero = sel ? (a == 16'd0 || b == 16'd0) : (a[7:0] == 8'd0 || b[7:0] == 8'd0);
    e.res = ref_prod(sel, a, b, tc_v);
    e.lat = is_zero ? 1 : (sel ? 17 : 9);
    sb.push_back(e);

    @(negedge clk);
    drive(1'b1, a, b);
    @(negedge clk);
    n      = 1;
    busy_n = 0;
    drive(1'b0, 16'($urandom), 16'($urandom));
    if (!is_zero) check("result_hold_at_start", cur_res, last_res[sel]);
    while (!cur_done && n < 40) begin
      if (cur_busy) busy_n++;
      drive(n == poke, 16'd2, 16'd2);
      @(negedge clk);
      n++;
    end
    if (cur_busy) busy_n++;
    got = sb.pop_front();
    check("done_latency", n, got.lat);
    check("result", cur_res, got.res);
    check("busy_cycles", busy_n, got.lat);

    // go during the DONE cycle must be ignored: back to idle, no second pulse.
    drive(1'b1, 16'd3, 16'd3);
    @(negedge clk);
    drive(1'b0, 16'd0, 16'd0);
    check("done_one_cycle_idle", {30'b0, cur_done, cur_busy}, 32'd0);
    last_res[sel] = got.res;
  endtask

  task automatic quiet(input int cycles);
    int d = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (cur_done) d++;
    end
    check("no_spurious_done", d, 0);
    check("result_held", cur_res, last_res[sel]);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    rst_n = 1'b0;
    tc_v  = 1'b0;
    sel   = 1'b0; drive(1'b0, 16'd0, 16'd0);
    sel   = 1'b1; drive(1'b0, 16'd0, 16'd0);
    last_res[0] = '0;
    last_res[1] = '0;
    #12;
    check("reset_busy8",   {31'b0, m8.busy},  32'd0);
    check("reset_done8",   {31'b0, m8.done},  32'd0);
    check("reset_result8", {16'b0, m8.Result}, 32'd0);
    check("reset_busy16",  {31'b0, m16.busy}, 32'd0);
    check("reset_result16", m16.Result,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 8-bit directed cases
    sel = 1'b0;
    run(16'd13,  16'd11,  -1);
    run(16'hFF,  16'hFF,  -1);
    run(16'd0,   16'h55,  -1);
    run(16'd1,   16'd0,   -1);
    run(16'd7,   16'd6,    3);
    quiet(12);
    run(16'd2,   16'd2,   -1);
    run(16'd128, 16'd1,   -1);

`ifdef MULT_SIGNED_EN
    tc_v = 1'b1;
    run(16'h80,  16'hFF,  -1);
    run(16'hFD,  16'h05,  -1);
    run(16'h80,  16'h80,  -1);
    run(16'h00,  16'h80,  -1);
    tc_v = 1'b0;
    run(16'h80,  16'h02,  -1);
`endif

    // Asynchronous reset in the middle of a calculation
    @(negedge clk);
    drive(1'b1, 16'd200, 16'd100);
    @(negedge clk);
    drive(1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",   {31'b0, m8.busy},   32'd0);
    check("abort_done",   {31'b0, m8.done},   32'd0);
    check("abort_result", {16'b0, m8.Result}, 32'd0);
    last_res[0] = '0;
    last_res[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet(15);

    // 16-bit directed corners and random sweep
    sel = 1'b1;
    run(16'hFFFF, 16'hFFFF, -1);
    run(16'h8000, 16'h0002, -1);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(15) == 0) ra = 16'd0;
`ifdef MULT_SIGNED_EN
      tc_v = 1'($urandom_range(1));
`endif
      run(ra, rb, -1);
    end
    tc_v = 1'b0;
    quiet(20);

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
